// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule controller: S-box, xtime, state encoding
// and width constants.
package aes_pkg;

    localparam int unsigned KEY_W     = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: derives the next round key from the previous
// one and the current round constant. Purely combinational.
module aes_key_round_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, tmp_w;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0    = prev_key[127:96];
        w1    = prev_key[95:64];
        w2    = prev_key[63:32];
        w3    = prev_key[31:0];
        rot_w = {w3[23:0], w3[31:24]};
        sub_w = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            sub_w[8*b +: 8] = sbox(rot_w[8*b +: 8]);
        end
        tmp_w    = sub_w ^ {rcon, 24'h0};
        n0       = w0 ^ tmp_w;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared round step, NR cycles per key.
// Optional KEY_ZEROIZE_EN adds a zeroize input that wipes all stored round keys.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key,
    output logic             key_ready,
    input  logic             key_lock,
`ifdef KEY_ZEROIZE_EN
    input  logic             zeroize,
`endif
    output logic             keys_ready,
    output logic             busy,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_data
);

    ks_state_e        state_q, state_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [KEY_W-1:0] rk_q [NR+1];
    logic [KEY_W-1:0] rk_d [NR+1];
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;

    aes_key_round_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon_q),
        .next_key (next_key)
    );

    assign keys_ready = (state_q == READY);
    assign busy       = (state_q == EXPAND);

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        rcon_d      = rcon_q;
        rk_d        = rk_q;
        key_ready   = 1'b0;
        prev_key    = '0;

        for (int unsigned i = 0; i < NR; i++) begin
            if (round_cnt_q == 4'(i + 1)) prev_key = rk_q[i];
        end

        case (state_q)
            IDLE:    key_ready = 1'b1;
            READY:   key_ready = !key_lock;
            default: key_ready = 1'b0;
        endcase

        case (state_q)
            IDLE, READY: begin
                if (key_valid && key_ready) begin
                    rk_d[0]     = key;
                    round_cnt_d = 4'd1;
                    rcon_d      = RCON_INIT;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                for (int unsigned i = 1; i <= NR; i++) begin
                    if (round_cnt_q == 4'(i)) rk_d[i] = next_key;
                end
                rcon_d      = xtime(rcon_q);
                round_cnt_d = round_cnt_q + 4'd1;
                if (round_cnt_q == 4'(NR)) state_d = READY;
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_ZEROIZE_EN
        // Wipe overrides everything above, including an accept in the same cycle.
        if (zeroize) begin
            for (int unsigned i = 0; i <= NR; i++) rk_d[i] = '0;
            state_d     = IDLE;
            round_cnt_d = '0;
            rcon_d      = RCON_INIT;
        end
`endif
    end

    always_comb begin
        rk_data = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (rk_idx == 4'(i)) rk_data = rk_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            round_cnt_q <= '0;
            rcon_q      <= RCON_INIT;
            for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            rcon_q      <= rcon_d;
            rk_q        <= rk_d;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
// Define KEY_ZEROIZE_EN to also exercise the zeroize input.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         reset_n;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         key_lock;
    logic         keys_ready;
    logic         busy;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
`ifdef KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .key_lock   (key_lock),
`ifdef KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .keys_ready (keys_ready),
        .busy       (busy),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         krdy;
        logic         ksrdy;
        logic         bsy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected record per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (rk_data !== e.data || key_ready !== e.krdy ||
                keys_ready !== e.ksrdy || busy !== e.bsy) begin
                n_miss++;
                $display("FAIL %s idx=%0d got rk=%h key_ready=%b keys_ready=%b busy=%b want rk=%h key_ready=%b keys_ready=%b busy=%b",
                         nm, e.idx, rk_data, key_ready, keys_ready, busy,
                         e.data, e.krdy, e.ksrdy, e.bsy);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] idx, input logic [127:0] d,
                       input logic krdy, input logic ksrdy, input logic bsy);
        rk_idx = idx;
        name_q.push_back(nm);
        exp_q.push_back({idx, d, krdy, ksrdy, bsy});
    endtask

    initial begin
        reset_n   = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        key_lock  = 1'b0;
        rk_idx    = '0;
`ifdef KEY_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        #2 reset_n = 1'b0;
        cyc();
        chk("reset_rk0", 4'd0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("reset_rk10", 4'd10, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        reset_n = 1'b1;

        // Test 1: expansion of K1 and latency of keys_ready.
        key = K1;
        key_valid = 1'b1;
        chk("t1_idle", 4'd0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t1_expand", 4'd0, K1, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("t1_rk10", 4'd10, K1_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("t1_rk1", 4'd1, K1_R1, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("t1_rk0", 4'd0, K1, 1'b1, 1'b1, 1'b0);
        cyc();

        // Test 2: reload attempt during expansion must wait for completion.
        key = K1;
        key_valid = 1'b1;
        chk("t2_ready", 4'd10, K1_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        for (int k = 0; k < 10; k++) begin
            if (k == 2) key = K2;
            chk("t2_no_reload", 4'd0, K1, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("t2_k1_intact", 4'd10, K1_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) chk("t2_exp_rk0", 4'd0, K2, 1'b0, 1'b0, 1'b1);
            else            chk("t2_stale_rk10", 4'd10, K1_R10, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("t2_k2_rk10", 4'd10, K2_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("t2_k2_rk1", 4'd1, K2_R1, 1'b1, 1'b1, 1'b0);
        cyc();

        // Test 3: key_lock blocks accept in READY.
        key_lock  = 1'b1;
        key_valid = 1'b1;
        key       = K1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_locked", 4'd10, K2_R10, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        key_lock = 1'b0;
        chk("t3_unlock", 4'd10, K2_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        key_valid = 1'b0;
        chk("t3_accepted", 4'd0, K1, 1'b0, 1'b0, 1'b1);
        cyc();

        // Test 4: asynchronous reset during expansion.
        chk("t4_expand", 4'd1, K1_R1, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("t4_expand", 4'd0, K1, 1'b0, 1'b0, 1'b1);
        cyc();
        reset_n = 1'b0;
        chk("t4_async_reset", 4'd1, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_cleared", 4'(i), '0, 1'b1, 1'b0, 1'b0);
            cyc();
        end

        // Test 5: out-of-range indices read as zero.
        key = K1;
        key_valid = 1'b1;
        chk("t5_idle", 4'd0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t5_expand", 4'd0, K1, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("t5_rk10", 4'd10, K1_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        for (int i = 11; i < 16; i++) begin
            chk("t5_oob", 4'(i), '0, 1'b1, 1'b1, 1'b0);
            cyc();
        end

`ifdef KEY_ZEROIZE_EN
        // Test 6: zeroize wins over a simultaneous accept.
        zeroize   = 1'b1;
        key_valid = 1'b1;
        key       = K2;
        chk("t6_pre", 4'd10, K1_R10, 1'b1, 1'b1, 1'b0);
        cyc();
        zeroize   = 1'b0;
        key_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk("t6_zeroized", 4'(i), '0, 1'b1, 1'b0, 1'b0);
            cyc();
        end
`endif

        cyc();
        cyc();
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
